// File: rtl/hamming_7_4_serial_tx.sv
// Hamming(7,4) encoder and LSB-first serializer with framing strobe and optional inter-frame gap.
// Define HAMMING_TX_ERR_INJECT_EN to add single-bit error injection for decoder loopback tests.
module hamming_7_4_serial_tx #(
    parameter int GAP_CYCLES = 0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] i_data,
    input  logic       i_valid,
    output logic       o_ready,
    input  logic       i_tx_en,
`ifdef HAMMING_TX_ERR_INJECT_EN
    input  logic       i_flip_en,
    input  logic [2:0] i_flip_pos,
`endif
    output logic       o_bit,
    output logic       o_bit_valid,
    output logic       o_sof,
    output logic       o_busy
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_GAP   = 2'd2
    } state_t;

    localparam bit         HAS_GAP  = (GAP_CYCLES > 0);
    localparam logic [3:0] GAP_LAST = HAS_GAP ? 4'(GAP_CYCLES - 1) : 4'd0;

    // Bit layout must match hamming_7_4_decoder on the receive side.
    function automatic logic [6:0] encode(input logic [3:0] d);
        logic [6:0] cw;
        cw[2] = d[0];
        cw[4] = d[1];
        cw[5] = d[2];
        cw[6] = d[3];
        cw[0] = d[0] ^ d[1] ^ d[3];
        cw[1] = d[0] ^ d[2] ^ d[3];
        cw[3] = d[1] ^ d[2] ^ d[3];
        return cw;
    endfunction

    state_t     state_q, state_d;
    logic [6:0] sr_q, sr_d;
    logic [2:0] bit_cnt_q, bit_cnt_d;
    logic [3:0] gap_cnt_q, gap_cnt_d;
    logic       bit_q, bit_valid_q, sof_q, busy_q;

    logic [6:0] flip_mask;
    logic [6:0] cw_load;
    logic       last_bit;

`ifdef HAMMING_TX_ERR_INJECT_EN
    always_comb begin
        flip_mask = 7'd0;
        if (i_flip_en && (i_flip_pos != 3'd7)) begin
            flip_mask = 7'd1 << i_flip_pos;
        end
    end
`else
    assign flip_mask = 7'd0;
`endif

    assign cw_load  = encode(i_data) ^ flip_mask;
    assign last_bit = (state_q == ST_SHIFT) && (bit_cnt_q == 3'd6) && i_tx_en;
    // Without a gap the final-bit cycle doubles as the accept slot for back-to-back frames.
    assign o_ready  = (state_q == ST_IDLE) || (!HAS_GAP && last_bit);

    always_comb begin
        state_d   = state_q;
        sr_d      = sr_q;
        bit_cnt_d = bit_cnt_q;
        gap_cnt_d = gap_cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (i_valid) begin
                    state_d   = ST_SHIFT;
                    sr_d      = cw_load;
                    bit_cnt_d = 3'd0;
                end
            end
            ST_SHIFT: begin
                if (i_tx_en) begin
                    sr_d      = {1'b0, sr_q[6:1]};
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd6) begin
                        bit_cnt_d = 3'd0;
                        if (HAS_GAP) begin
                            state_d   = ST_GAP;
                            gap_cnt_d = 4'd0;
                        end else if (i_valid) begin
                            sr_d = cw_load;
                        end else begin
                            state_d = ST_IDLE;
                        end
                    end
                end
            end
            ST_GAP: begin
                if (i_tx_en) begin
                    if (gap_cnt_q == GAP_LAST) begin
                        state_d   = ST_IDLE;
                        gap_cnt_d = 4'd0;
                    end else begin
                        gap_cnt_d = gap_cnt_q + 4'd1;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Outputs are registered from next-state values so they line up with the shift register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            sr_q        <= 7'd0;
            bit_cnt_q   <= 3'd0;
            gap_cnt_q   <= 4'd0;
            bit_q       <= 1'b0;
            bit_valid_q <= 1'b0;
            sof_q       <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            sr_q        <= sr_d;
            bit_cnt_q   <= bit_cnt_d;
            gap_cnt_q   <= gap_cnt_d;
            bit_q       <= (state_d == ST_SHIFT) && sr_d[0];
            bit_valid_q <= (state_d == ST_SHIFT);
            sof_q       <= (state_d == ST_SHIFT) && (bit_cnt_d == 3'd0);
            busy_q      <= (state_d != ST_IDLE);
        end
    end

    assign o_bit       = bit_q;
    assign o_bit_valid = bit_valid_q;
    assign o_sof       = sof_q;
    assign o_busy      = busy_q;

endmodule

// File: tb/tb_hamming_7_4_serial_tx.sv
// Bench for hamming_7_4_serial_tx: one instance without gap, one with GAP_CYCLES=2,
// checked against a position-based Hamming reference model.
module tb_hamming_7_4_serial_tx;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic [3:0] data;
    logic       tx_en;
    logic       a_valid, b_valid;
    logic       a_ready, a_bit, a_bvld, a_sof, a_busy;
    logic       b_ready, b_bit, b_bvld, b_sof, b_busy;
`ifdef HAMMING_TX_ERR_INJECT_EN
    logic       flip_en;
    logic [2:0] flip_pos;
`endif

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    hamming_7_4_serial_tx #(.GAP_CYCLES(0)) u_a (
        .clk(clk), .rst_n(rst_n), .i_data(data), .i_valid(a_valid), .o_ready(a_ready),
        .i_tx_en(tx_en),
`ifdef HAMMING_TX_ERR_INJECT_EN
        .i_flip_en(flip_en), .i_flip_pos(flip_pos),
`endif
        .o_bit(a_bit), .o_bit_valid(a_bvld), .o_sof(a_sof), .o_busy(a_busy)
    );

    hamming_7_4_serial_tx #(.GAP_CYCLES(2)) u_b (
        .clk(clk), .rst_n(rst_n), .i_data(data), .i_valid(b_valid), .o_ready(b_ready),
        .i_tx_en(tx_en),
`ifdef HAMMING_TX_ERR_INJECT_EN
        .i_flip_en(flip_en), .i_flip_pos(flip_pos),
`endif
        .o_bit(b_bit), .o_bit_valid(b_bvld), .o_sof(b_sof), .o_busy(b_busy)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Codeword bit i is Hamming position i+1; parity sits at positions 1,2,4 and
    // each parity makes the XOR over all positions sharing its index bit zero.
    function automatic logic [6:0] ref_encode(input logic [3:0] d);
        logic [6:0] cw;
        int         j;
        logic       par;
        cw = 7'd0;
        j  = 0;
        for (int pos = 1; pos <= 7; pos++) begin
            if ((pos & (pos - 1)) != 0) begin
                cw[pos-1] = d[j];
                j++;
            end
        end
        for (int p = 1; p <= 4; p = p * 2) begin
            par = 1'b0;
            for (int pos = 1; pos <= 7; pos++) begin
                if (((pos & p) != 0) && (pos != p)) par = par ^ cw[pos-1];
            end
            cw[p-1] = par;
        end
        return cw;
    endfunction

`ifdef HAMMING_TX_ERR_INJECT_EN
    function automatic logic [3:0] ref_decode(input logic [6:0] cw_in);
        logic [6:0] cw;
        int         syn;
        cw  = cw_in;
        syn = 0;
        for (int pos = 1; pos <= 7; pos++) if (cw[pos-1]) syn = syn ^ pos;
        if (syn != 0) cw[syn-1] = ~cw[syn-1];
        return {cw[6], cw[5], cw[4], cw[2]};
    endfunction
`endif

    // Called at posedge+1; returns at posedge+1 after the accepting edge.
    task automatic offer(input bit use_b, input logic [3:0] d, input bit keep);
        int n;
        n    = 0;
        data = d;
        if (use_b) b_valid = 1'b1; else a_valid = 1'b1;
        @(negedge clk);
        while (!(use_b ? b_ready : a_ready) && n < 40) begin
            @(negedge clk);
            n++;
        end
        check("offer_ready", 32'(use_b ? b_ready : a_ready), 32'(1));
        @(posedge clk);
        #1;
        if (!keep) begin
            a_valid = 1'b0;
            b_valid = 1'b0;
        end
    endtask

    task automatic watch_frame(input bit use_b, input logic [6:0] cw, input int stall_at,
                               input int stall_len, input bit rnd, input bit exp_rdy_last,
                               output int cycles, output logic [6:0] got);
        int k;
        int hold;
        bit en;
        k      = 0;
        hold   = 0;
        cycles = 0;
        got    = 7'd0;
        while (k < 7 && cycles < 60) begin
            if (rnd) en = ($urandom_range(0, 3) != 0);
            else     en = !(k == stall_at && hold < stall_len);
            tx_en = en;
            @(negedge clk);
            got[k] = use_b ? b_bit : a_bit;
            check("bit_valid", 32'(use_b ? b_bvld : a_bvld), 32'(1));
            check("bit", 32'(use_b ? b_bit : a_bit), 32'(cw[k]));
            check("sof", 32'(use_b ? b_sof : a_sof), 32'(k == 0));
            check("busy", 32'(use_b ? b_busy : a_busy), 32'(1));
            check("ready_in_frame", 32'(use_b ? b_ready : a_ready), 32'(k == 6 && en && exp_rdy_last));
            @(posedge clk);
            #1;
            cycles++;
            if (en) k++; else hold++;
        end
        tx_en = 1'b1;
        check("frame_done", 32'(k), 32'(7));
    endtask

    task automatic idle_check(input bit use_b, input string tag);
        @(negedge clk);
        check({tag, "_busy"}, 32'(use_b ? b_busy : a_busy), 32'(0));
        check({tag, "_ready"}, 32'(use_b ? b_ready : a_ready), 32'(1));
        check({tag, "_bvld"}, 32'(use_b ? b_bvld : a_bvld), 32'(0));
        @(posedge clk);
        #1;
    endtask

    task automatic gap_check(input bit stall_first);
        if (stall_first) begin
            tx_en = 1'b0;
            @(negedge clk);
            check("gap_hold_bvld", 32'(b_bvld), 32'(0));
            check("gap_hold_ready", 32'(b_ready), 32'(0));
            check("gap_hold_busy", 32'(b_busy), 32'(1));
            @(posedge clk);
            #1;
            tx_en = 1'b1;
        end
        for (int n = 0; n < 2; n++) begin
            @(negedge clk);
            check("gap_bvld", 32'(b_bvld), 32'(0));
            check("gap_bit", 32'(b_bit), 32'(0));
            check("gap_ready", 32'(b_ready), 32'(0));
            check("gap_busy", 32'(b_busy), 32'(1));
            @(posedge clk);
            #1;
        end
        idle_check(1'b1, "post_gap");
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        failures++;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int         cyc;
        logic [6:0] got;
        logic [3:0] d;
        data    = 4'd0;
        tx_en   = 1'b1;
        a_valid = 1'b0;
        b_valid = 1'b0;
`ifdef HAMMING_TX_ERR_INJECT_EN
        flip_en  = 1'b0;
        flip_pos = 3'd7;
`endif
        #2 rst_n = 1'b0;
        #10;
        check("rst_bit", 32'(a_bit), 32'(0));
        check("rst_bvld", 32'(a_bvld), 32'(0));
        check("rst_sof", 32'(a_sof), 32'(0));
        check("rst_busy", 32'(a_busy), 32'(0));
        check("rst_ready", 32'(a_ready), 32'(1));
        check("rst_ready_b", 32'(b_ready), 32'(1));
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Single word 1010 -> cw 1010010, then IDLE
        offer(1'b0, 4'b1010, 1'b0);
        watch_frame(1'b0, 7'b1010010, -1, 0, 1'b0, 1'b1, cyc, got);
        check("frame_len_1010", 32'(cyc), 32'(7));
        idle_check(1'b0, "idle_1010");

        // Back-to-back 1001 then 1111 with valid held
        offer(1'b0, 4'b1001, 1'b1);
        data = 4'b1111;
        watch_frame(1'b0, 7'b1001100, -1, 0, 1'b0, 1'b1, cyc, got);
        a_valid = 1'b0;
        watch_frame(1'b0, 7'b1111111, -1, 0, 1'b0, 1'b1, cyc, got);
        idle_check(1'b0, "idle_b2b");

        // Line stall of 3 cycles at bit 3
        offer(1'b0, 4'b0000, 1'b0);
        watch_frame(1'b0, 7'b0000000, 3, 3, 1'b0, 1'b1, cyc, got);
        check("frame_len_stall", 32'(cyc), 32'(10));
        idle_check(1'b0, "idle_stall");

        // Stall exactly on the last bit of a frame with a word waiting
        offer(1'b0, 4'b0110, 1'b1);
        data = 4'b1011;
        watch_frame(1'b0, ref_encode(4'b0110), 6, 2, 1'b0, 1'b1, cyc, got);
        a_valid = 1'b0;
        check("frame_len_last_stall", 32'(cyc), 32'(9));
        watch_frame(1'b0, ref_encode(4'b1011), -1, 0, 1'b0, 1'b1, cyc, got);
        idle_check(1'b0, "idle_last_stall");

        // Asynchronous reset at bit 4 of 0111
        offer(1'b0, 4'b0111, 1'b0);
        repeat (4) @(posedge clk);
        @(negedge clk);
        check("pre_rst_bit", 32'(a_bit), 32'(1));
        check("pre_rst_bvld", 32'(a_bvld), 32'(1));
        #1 rst_n = 1'b0;
        #1;
        check("async_rst_bit", 32'(a_bit), 32'(0));
        check("async_rst_bvld", 32'(a_bvld), 32'(0));
        check("async_rst_busy", 32'(a_busy), 32'(0));
        check("async_rst_ready", 32'(a_ready), 32'(1));
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        offer(1'b0, 4'b0101, 1'b0);
        watch_frame(1'b0, ref_encode(4'b0101), -1, 0, 1'b0, 1'b1, cyc, got);
        idle_check(1'b0, "idle_after_rst");

        // GAP_CYCLES=2: gap then one IDLE cycle, with a word waiting
        offer(1'b1, 4'b0110, 1'b0);
        watch_frame(1'b1, ref_encode(4'b0110), -1, 0, 1'b0, 1'b0, cyc, got);
        data    = 4'b1100;
        b_valid = 1'b1;
        gap_check(1'b0);
        b_valid = 1'b0;
        watch_frame(1'b1, ref_encode(4'b1100), -1, 0, 1'b0, 1'b0, cyc, got);
        gap_check(1'b1);

        // Randomized frames on both instances
        for (int i = 0; i < 25; i++) begin
            d = 4'($urandom);
            offer(1'b0, d, 1'b0);
            watch_frame(1'b0, ref_encode(d), -1, 0, 1'b1, 1'b1, cyc, got);
            if ($urandom_range(0, 1) == 0) idle_check(1'b0, "rnd_idle");
        end
        for (int i = 0; i < 6; i++) begin
            d = 4'($urandom);
            offer(1'b1, d, 1'b0);
            watch_frame(1'b1, ref_encode(d), -1, 0, 1'b1, 1'b0, cyc, got);
            gap_check(1'($urandom_range(0, 1)));
        end

`ifdef HAMMING_TX_ERR_INJECT_EN
        flip_en  = 1'b1;
        flip_pos = 3'd5;
        offer(1'b0, 4'b0111, 1'b0);
        flip_en  = 1'b0;
        flip_pos = 3'd0;
        watch_frame(1'b0, 7'b0010100, -1, 0, 1'b0, 1'b1, cyc, got);
        check("loopback_0111", 32'(ref_decode(got)), 32'(4'b0111));
        for (int i = 0; i < 10; i++) begin
            d        = 4'($urandom);
            flip_en  = 1'b1;
            flip_pos = 3'($urandom_range(0, 7));
            offer(1'b0, d, 1'b0);
            watch_frame(1'b0, ref_encode(d) ^ ((flip_pos == 3'd7) ? 7'd0 : (7'd1 << flip_pos)),
                        -1, 0, 1'b0, 1'b1, cyc, got);
            flip_en = 1'b0;
            check("loopback_rnd", 32'(ref_decode(got)), 32'(d));
        end
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
